// File: rtl/led_frame_loader.sv
// Collects a host byte stream into one LED frame, hands it to the serial driver,
// then holds off new bytes until the strip's latch gap has elapsed.
module led_frame_loader #(
  parameter int unsigned NUM_LEDS     = 60,
  parameter int unsigned LATCH_CYCLES = 1200
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              in_byte,
  input  logic                    in_valid,
  input  logic                    in_sof,
  output logic                    in_ready,
  output logic [NUM_LEDS*24-1:0]  out_data,
  output logic                    start,
  input  logic                    finish,
  output logic                    busy,
  output logic                    frame_err
);

  localparam int unsigned NumBytes = 3 * NUM_LEDS;
  localparam int unsigned IdxW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;
  localparam int unsigned LatW     = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NumBytes - 1);
  localparam logic [LatW-1:0] LatLast = LatW'(LATCH_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StSend, StLatch} state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [LatW-1:0]         lat_q, lat_d;
  logic                    err_q, err_d;
  logic [NUM_LEDS*24-1:0]  data_q;

  logic                    accept;
  logic                    wr_en;
  logic [IdxW-1:0]         wr_idx;

  // in_ready decodes the state register only, so it never depends on in_valid.
  assign in_ready  = (state_q == StIdle) || (state_q == StLoad);
  assign start     = (state_q == StStart);
  assign busy      = (state_q != StIdle);
  assign frame_err = err_q;
  assign out_data  = data_q;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lat_d   = lat_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = idx_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (in_sof) begin
            wr_en  = 1'b1;
            wr_idx = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (accept) begin
          wr_en = 1'b1;
          // A new sof mid-frame restarts the frame from byte 0.
          if (in_sof) begin
            err_d  = 1'b1;
            wr_idx = '0;
          end
        end
      end
      StStart: state_d = StSend;
      StSend: begin
        if (finish) begin
          state_d = StLatch;
          lat_d   = '0;
        end
      end
      StLatch: begin
        if (lat_q == LatLast) state_d = StIdle;
        else                  lat_d   = lat_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
    if (wr_en) begin
      if (wr_idx == IdxLast) begin
        state_d = StStart;
        idx_d   = '0;
      end else begin
        state_d = StLoad;
        idx_d   = wr_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      lat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lat_q   <= lat_d;
      err_q   <= err_d;
    end
  end

  // Byte k lands in the top-down byte lane so byte 0 is shifted out first.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else if (wr_en) begin
      for (int unsigned b = 0; b < NumBytes; b++) begin
        if (wr_idx == IdxW'(b)) data_q[(NumBytes-1-b)*8 +: 8] <= in_byte;
      end
    end
  end

endmodule

// File: tb/tb_led_frame_loader.sv
// Directed bench for led_frame_loader with NUM_LEDS=2, LATCH_CYCLES=4.
module tb_led_frame_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic        in_ready;
  logic [47:0] out_data;
  logic        start;
  logic        finish = 1'b0;
  logic        busy;
  logic        frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;
  int err_cnt   = 0;

  led_frame_loader #(.NUM_LEDS(2), .LATCH_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .start     (start),
    .finish    (finish),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && start)     start_cnt++;
    if (!reset && frame_err) err_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents the six bytes of a frame back-to-back, sof on the first.
  task automatic send_frame(input logic [47:0] frame);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_sof   = (i == 0);
      in_byte  = frame[(5-i)*8 +: 8];
      tick();
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // From SEND: one-cycle finish, then the four latch cycles back to IDLE.
  task automatic finish_frame();
    finish = 1'b1;
    tick();
    finish = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL reset_start got %b want 0", start); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", frame_err); end
    n_checks++; if (out_data !== 48'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", out_data); end
  endtask

  task automatic test_load();
    int s0;
    s0 = start_cnt;
    send_frame(48'h112233445566);
    n_checks++; if (start !== 1'b1) begin n_fail++; $display("FAIL load_start got %b want 1", start); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL load_busy got %b want 1", busy); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready got %b want 0", in_ready); end
    n_checks++; if (out_data !== 48'h112233445566) begin n_fail++; $display("FAIL load_data got %h want 112233445566", out_data); end
    tick();
    n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL load_start_one got %b want 0", start); end
    n_checks++; if (start_cnt !== s0 + 1) begin n_fail++; $display("FAIL load_start_cnt got %0d want %0d", start_cnt, s0 + 1); end
  endtask

  task automatic test_send_latch();
    int s0;
    s0 = start_cnt;
    repeat (8) tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL send_ready got %b want 0", in_ready); end
    finish = 1'b1;
    tick();
    // finish stays high through LATCH and must not matter
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL latch_%0d got ready=%b busy=%b want 0/1", k, in_ready, busy); end
      tick();
    end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL latch_done_ready got %b want 1", in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL latch_done_busy got %b want 0", busy); end
    tick();
    finish = 1'b0;
    n_checks++; if (busy !== 1'b0 || start_cnt !== s0) begin n_fail++; $display("FAIL finish_idle got busy=%b starts=%0d want 0/%0d", busy, start_cnt, s0); end
  endtask

  task automatic test_err_idle();
    int e0;
    e0 = err_cnt;
    in_valid = 1'b1; in_sof = 1'b0; in_byte = 8'hAA;
    tick();
    in_valid = 1'b0;
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL idle_err got %b want 1", frame_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_err_busy got %b want 0", busy); end
    n_checks++; if (out_data !== 48'h112233445566) begin n_fail++; $display("FAIL idle_err_data got %h want 112233445566", out_data); end
    tick();
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL idle_err_pulse got %b want 0", frame_err); end
    n_checks++; if (err_cnt !== e0 + 1) begin n_fail++; $display("FAIL idle_err_cnt got %0d want %0d", err_cnt, e0 + 1); end
  endtask

  task automatic test_restart();
    int e0, s0;
    e0 = err_cnt;
    s0 = start_cnt;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_sof = (i == 0); in_byte = 8'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    n_checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL partial got busy=%b ready=%b want 1/1", busy, in_ready); end
    send_frame(48'h102030405060);
    n_checks++; if (err_cnt !== e0 + 1) begin n_fail++; $display("FAIL restart_err_cnt got %0d want %0d", err_cnt, e0 + 1); end
    n_checks++; if (out_data !== 48'h102030405060) begin n_fail++; $display("FAIL restart_data got %h want 102030405060", out_data); end
    // finish during the START cycle must not end SEND
    finish = 1'b1;
    tick();
    finish = 1'b0;
    repeat (6) tick();
    n_checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL start_finish got busy=%b ready=%b want 1/0", busy, in_ready); end
    n_checks++; if (start_cnt !== s0 + 1) begin n_fail++; $display("FAIL restart_starts got %0d want %0d", start_cnt, s0 + 1); end
    finish_frame();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL restart_idle got %b want 0", busy); end
  endtask

  task automatic test_reset_send();
    int s0, e0;
    send_frame(48'hA1A2A3A4A5A6);
    tick();
    s0 = start_cnt;
    e0 = err_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (out_data !== 48'h0) begin n_fail++; $display("FAIL rst_send_data got %h want 0", out_data); end
    n_checks++; if (busy !== 1'b0 || start !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_send_ctl got busy=%b start=%b ready=%b want 0/0/1", busy, start, in_ready); end
    finish = 1'b1;
    tick();
    finish = 1'b0;
    repeat (5) tick();
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_finish got busy=%b ready=%b want 0/1", busy, in_ready); end
    n_checks++; if (start_cnt !== s0 || err_cnt !== e0) begin n_fail++; $display("FAIL rst_pulses got starts=%0d errs=%0d want %0d/%0d", start_cnt, err_cnt, s0, e0); end
    send_frame(48'hC1C2C3C4C5C6);
    n_checks++; if (out_data !== 48'hC1C2C3C4C5C6 || start !== 1'b1) begin n_fail++; $display("FAIL rst_reload got %h start=%b want c1c2c3c4c5c6/1", out_data, start); end
    tick();
    finish_frame();
  endtask

  task automatic test_back_to_back();
    int s0, e0;
    logic [47:0] frame;
    frame = 48'h0F1E2D3C4B5A;
    s0 = start_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_sof = (i == 0); in_byte = frame[(5-i)*8 +: 8];
      tick();
      in_valid = 1'b0; in_sof = 1'b1; in_byte = 8'hEE;
      tick();
    end
    // valid held with junk through SEND must be ignored
    in_valid = 1'b1; in_sof = 1'b0; in_byte = 8'h99;
    repeat (5) tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready got %b want 0", in_ready); end
    n_checks++; if (out_data !== frame) begin n_fail++; $display("FAIL b2b_data got %h want %h", out_data, frame); end
    n_checks++; if (start_cnt !== s0 + 1 || err_cnt !== e0) begin n_fail++; $display("FAIL b2b_pulses got starts=%0d errs=%0d want %0d/%0d", start_cnt, err_cnt, s0 + 1, e0); end
    in_valid = 1'b0;
    finish_frame();
    n_checks++; if (busy !== 1'b0 || out_data !== frame) begin n_fail++; $display("FAIL b2b_end got busy=%b data=%h want 0/%h", busy, out_data, frame); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_send_latch();
    test_err_idle();
    test_restart();
    test_reset_send();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/led_frame_loader.md
LED_FRAME_LOADER -- requirements
Module: led_frame_loader

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 60, number of 24-bit LEDs per frame (frame = 3*NUM_LEDS bytes).
REQ-002 SHALL have parameter LATCH_CYCLES, default 1200, minimum idle-low gap after a frame (60 us at 20 MHz).
REQ-003 SHALL have port clk  input  1  clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_byte  input  8  colour byte from host byte stream.
REQ-006 SHALL have port in_valid  input  1  in_byte valid.
REQ-007 SHALL have port in_sof  input  1  qualifies in_byte as first byte of a frame.
REQ-008 SHALL have port in_ready  output  1  byte accepted on cycle with in_valid and in_ready both high.
REQ-009 SHALL have port out_data  output  NUM_LEDS*24  frame to serial LED driver, MSB transmitted first.
REQ-010 SHALL have port start  output  1  one-cycle pulse requesting driver transmit out_data.
REQ-011 SHALL have port finish  input  1  driver done with frame.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse on protocol error.

Function
REQ-014 SHALL implement states IDLE, LOAD, START, SEND, LATCH.
REQ-015 SHALL keep a byte index 0..3*NUM_LEDS-1; byte k written to out_data[(3*NUM_LEDS-k)*8-1 -: 8], i.e. byte 0 in top byte.
REQ-016 in_ready SHALL be 1 in IDLE and LOAD, 0 in START, SEND, LATCH (registered from state, no combinational path from in_valid).
REQ-017 IDLE: accepted byte with in_sof=1 SHALL write index 0, set index to 1, go LOAD; accepted byte with in_sof=0 SHALL be discarded and pulse frame_err next cycle.
REQ-018 LOAD: accepted byte with in_sof=0 SHALL write at index, increment index; with in_sof=1 SHALL pulse frame_err, write at index 0, set index to 1 (restart, prior partial bytes overwritten).
REQ-019 Accepting byte index 3*NUM_LEDS-1 SHALL transition to START on next cycle; for NUM_LEDS*3=1 the sof byte itself completes the frame.
REQ-020 START: start SHALL be 1 for exactly one cycle, then state SEND.
REQ-021 SEND: stay until finish=1, then LATCH with latch counter loaded to 0.
REQ-022 LATCH: count LATCH_CYCLES cycles, then IDLE; first byte accepted no earlier than LATCH_CYCLES+1 cycles after finish sampled.
REQ-023 out_data SHALL be unchanged from START entry until return to IDLE.
REQ-024 finish SHALL be ignored in all states other than SEND; finish in same cycle as START SHALL NOT be taken (SEND samples first).
REQ-025 in_valid with in_ready=0 SHALL have no effect; no bytes buffered.
REQ-026 Index and latch counters SHALL be sized clog2 of their maxima, no wrap beyond terminal value.

Reset
REQ-027 On reset: state IDLE, index 0, latch counter 0, out_data all 0, start 0, frame_err 0, busy 0, in_ready 1 on the cycle after reset deasserts.
REQ-028 Reset asserted mid-LOAD, SEND or LATCH SHALL abandon frame without start or frame_err pulse.

Verification (NUM_LEDS=2, LATCH_CYCLES=4)
REQ-029 Bytes 11,22,33,44,55,66 (sof on 11), back-to-back -> out_data=0x112233445566, single start pulse the cycle after 66 accepted, busy=1.
REQ-030 finish pulsed 10 cycles after start -> in_ready=0 until 4 latch cycles elapse, then in_ready=1, busy=0; finish held during LATCH has no effect.
REQ-031 Byte AA with in_sof=0 in IDLE -> frame_err one-cycle pulse, state stays IDLE, out_data unchanged.
REQ-032 Bytes 01,02,03 then sof byte 10 and 20,30,40,50,60 -> one frame_err pulse, out_data=0x102030405060, one start.
REQ-033 Reset during SEND -> out_data=0, start=0, busy=0, later finish ignored, next sof frame loads normally.
REQ-034 in_valid toggling every other cycle plus in_valid held during SEND -> only bytes with in_ready=1 written, correct order, no extra start.
